// File: rtl/lfsr_rand_stream.sv
// Galois-LFSR random source with reseed, rejection-sampled range limit and a valid/ready output.
// Optional RAND_STATS_EN adds saturating accepted/rejected counters.
module lfsr_rand_stream #(
  parameter int unsigned            WIDTH        = 8,
  parameter logic [WIDTH-1:0]       TAPS         = 8'hB8,
  parameter int unsigned            OUT_W        = 8,
  parameter logic [WIDTH-1:0]       DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [OUT_W-1:0] limit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             busy
`ifdef RAND_STATS_EN
  ,
  output logic [15:0]      gen_count,
  output logic [15:0]      rej_count
`endif
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             gen_slot;
  logic             admit;
  logic [OUT_W-1:0] cand;
  logic [WIDTH-1:0] step;

  assign accept   = valid_q && out_ready;
  assign gen_slot = en && !seed_load && (!valid_q || out_ready);
  assign cand     = state_q[OUT_W-1:0];
  assign admit    = (limit == '0) || (cand < limit);
  assign step     = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);

  // Reseed takes priority over both the handshake and generation in the same cycle.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    if (seed_load) begin
      state_d = (seed == '0) ? DEFAULT_SEED : seed;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      if (accept) valid_d = 1'b0;
      if (gen_slot) begin
        state_d = step;
        if (admit) begin
          data_d  = cand;
          valid_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          busy_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEFAULT_SEED;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

`ifdef RAND_STATS_EN
  logic [15:0] gen_q, gen_d;
  logic [15:0] rej_q, rej_d;

  always_comb begin
    gen_d = gen_q;
    rej_d = rej_q;
    if (seed_load) begin
      gen_d = '0;
      rej_d = '0;
    end else begin
      if (accept && gen_q != 16'hFFFF) gen_d = gen_q + 16'd1;
      if (gen_slot && !admit && rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen_q <= '0;
      rej_q <= '0;
    end else begin
      gen_q <= gen_d;
      rej_q <= rej_d;
    end
  end

  assign gen_count = gen_q;
  assign rej_count = rej_q;
`endif

endmodule

// File: tb/tb_lfsr_rand_stream.sv
// Bench for lfsr_rand_stream (default 8-bit configuration): reference model plus directed and random stimulus.
module tb_lfsr_rand_stream;

  localparam logic [7:0] MTAPS = 8'hB8;

  logic       clk = 1'b0;
  logic       rst, en, seed_load, out_ready;
  logic [7:0] seed, limit;
  logic       out_valid, busy;
  logic [7:0] out_data;
`ifdef RAND_STATS_EN
  logic [15:0] gen_count, rej_count;
`endif

  lfsr_rand_stream dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_load (seed_load),
    .seed      (seed),
    .limit     (limit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef RAND_STATS_EN
    ,
    .gen_count (gen_count),
    .rej_count (rej_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: what the stream must present, from the behavioural rules.
  int  m_state = 1;
  bit  m_valid = 1'b0;
  int  m_data  = 0;
  bit  m_busy  = 1'b0;
  int  m_gen   = 0;
  int  m_rej   = 0;
  logic [7:0] acc[$];

  function automatic int lfsr_next(input int s);
    if (s % 2 == 1) return (s / 2) ^ int'(MTAPS);
    return s / 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && !seed_load && out_valid && out_ready) acc.push_back(out_data);
    if (rst) begin
      m_state = 1; m_valid = 0; m_data = 0; m_busy = 0; m_gen = 0; m_rej = 0;
    end else if (seed_load) begin
      m_state = (seed == 0) ? 1 : int'(seed);
      m_valid = 0; m_busy = 0; m_gen = 0; m_rej = 0;
    end else begin
      bit slot_free;
      int c;
      slot_free = !m_valid || out_ready;
      if (m_valid && out_ready) begin
        m_valid = 0;
        if (m_gen < 65535) m_gen++;
      end
      if (en && slot_free) begin
        c = m_state;
        m_state = lfsr_next(m_state);
        if (limit == 0 || c < int'(limit)) begin
          m_data = c; m_valid = 1; m_busy = 0;
        end else begin
          m_busy = 1;
          if (m_rej < 65535) m_rej++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_out_data", 32'(out_data), 32'(m_data));
`ifdef RAND_STATS_EN
      chk("cyc_gen_count", 32'(gen_count), 32'(m_gen));
      chk("cyc_rej_count", 32'(rej_count), 32'(m_rej));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k = 0;
    while (acc.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (acc.size() < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout with %0d accepts, needed %0d", name, acc.size(), n);
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout, out_valid stayed 0", name);
    end
  endtask

  task automatic load(input logic [7:0] s);
    en = 0; seed_load = 1; seed = s;
    tick();
    seed_load = 0;
    acc.delete();
  endtask

  initial begin
    // Reset asserted together with load/en to show reset wins.
    rst = 1; en = 1; seed_load = 1; seed = 8'hAA; limit = 0; out_ready = 1;
    tick();
    tick();
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst = 0; seed_load = 0; en = 1; out_ready = 1;
    chk_on = 1'b1;
    acc.delete();
    wait_acc(2, 20, "reset_state_run");
    chk("reset_state_first", 32'(acc[0]), 32'h01);
    chk("reset_state_second", 32'(acc[1]), 32'hB8);

    // Sequence and full period from seed FF.
    load(8'hFF);
    en = 1; out_ready = 1; limit = 0;
    wait_acc(256, 600, "period_run");
    chk("seq_0", 32'(acc[0]), 32'hFF);
    chk("seq_1", 32'(acc[1]), 32'hC7);
    chk("seq_2", 32'(acc[2]), 32'hDB);
    begin
      int early = 0;
      for (int i = 1; i < 255; i++) if (acc[i] == 8'hFF) early++;
      chk("period_no_early_repeat", 32'(early), 32'h0);
    end
    chk("period_repeat", 32'(acc[255]), 32'hFF);

    // Backpressure holds the value without skipping.
    load(8'hFF);
    en = 1; out_ready = 0;
    wait_valid(10, "bp_first_valid");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", 32'(out_data), 32'hFF);
    end
    out_ready = 1;
    wait_acc(2, 20, "bp_release");
    chk("bp_acc_0", 32'(acc[0]), 32'hFF);
    chk("bp_acc_1", 32'(acc[1]), 32'hC7);

    // Zero seed falls back to the default seed.
    load(8'h00);
    en = 1; out_ready = 1;
    wait_acc(10, 40, "zero_seed_run");
    chk("zero_seed_first", 32'(acc[0]), 32'h01);
    begin
      int zeros = 0;
      for (int i = 0; i < 10; i++) if (acc[i] == 8'h00) zeros++;
      chk("zero_seed_no_zero", 32'(zeros), 32'h0);
    end

    // Range limiting by rejection.
    load(8'hFF);
    limit = 8'hD0; en = 1; out_ready = 1;
    tick();
    chk("range_ff_busy", 32'(busy), 32'h1);
    chk("range_ff_valid", 32'(out_valid), 32'h0);
    tick();
    chk("range_c7_valid", 32'(out_valid), 32'h1);
    chk("range_c7_data", 32'(out_data), 32'hC7);
    tick();
    chk("range_db_busy", 32'(busy), 32'h1);
    chk("range_db_valid", 32'(out_valid), 32'h0);
    wait_acc(2, 20, "range_second");
    chk("range_second_value", 32'(acc[1]), 32'h69);
    begin
      int k = 0;
      int over = 0;
      while (acc.size() < 1000 && k < 20000) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        k++;
      end
      out_ready = 1;
      chk("range_1000_reached", 32'(acc.size() >= 1000), 32'h1);
      foreach (acc[i]) if (acc[i] >= 8'hD0) over++;
      chk("range_all_below_limit", 32'(over), 32'h0);
    end

    // Reseed while a handshake is taking place.
    limit = 0; en = 1; out_ready = 1;
    wait_valid(20, "reseed_valid");
    begin
      int n;
      n = acc.size();
      seed_load = 1; seed = 8'h5A;
      tick();
      seed_load = 0;
      chk("reseed_valid_dropped", 32'(out_valid), 32'h0);
      chk("reseed_not_consumed", 32'(acc.size()), 32'(n));
`ifdef RAND_STATS_EN
      chk("reseed_gen_count", 32'(gen_count), 32'h0);
`endif
      wait_acc(n + 1, 20, "reseed_restart");
      chk("reseed_first", 32'(acc[n]), 32'h5A);
    end

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      seed_load = ($urandom_range(0, 49) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      en        = ($urandom_range(0, 4) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0)
        limit = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(16, 255));
      tick();
    end
    rst = 0; seed_load = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
